tonegen: RTL and testbench
==========================

# tonegen

Square-wave tone generator peripheral for the beeper/piezo output, sitting in the IO device class (0x0f) directly downstream of the address decoder. It consumes the decoder's `tonegen_period_cs`, `tonegen_duration_cs` and `tonegen_status_cs` selects. It produces `tonegen_data_out`/`tonegen_data_out_valid`, which feed the CPU read-data mux. A write to the duration register starts a tone: a 50% duty square wave at a programmed half-period, lasting a programmed number of millisecond ticks.

## Interface

Parameters:

- `TICK_DIVIDE`, default 50000: clocks per duration tick (1 ms at 50 MHz). Must be ≥ 1.

Ports:

- `clock` in 1: system clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low. Asserted when 0, sampled on `clock`.
- `write` in 1: CPU write strobe, qualified by a select.
- `read` in 1: CPU read strobe, qualified by a select.
- `data_in` in 32: CPU write data. Only `[15:0]` is used.
- `tonegen_period_cs` in 1: period register select.
- `tonegen_duration_cs` in 1: duration register select.
- `tonegen_status_cs` in 1: status register select.
- `tonegen_data_out` out 32: read data, `{31'b0, playing}`.
- `tonegen_data_out_valid` out 1: combinational `read & tonegen_status_cs`.
- `sounder` out 1: square-wave output to the pin.

## Operation

- Registers:
  - `period[15:0]`: half-period in clocks; 0 means silent.
  - `duration_count[15:0]`: remaining ticks.
  - `prescale` counter: 0..TICK_DIVIDE-1.
  - `tone_count[15:0]`.
  - `playing` state bit.
  - `sounder`.
- States: IDLE (`playing`=0) and PLAYING (`playing`=1).
- Period write (`write & tonegen_period_cs`):
  - Loads `period <= data_in[15:0]`.
  - Does not change state or counters; takes effect on the next compare.
- Duration write (`write & tonegen_duration_cs`):
  - `data_in[15:0]` ≠ 0:
    - `duration_count <= data_in[15:0]`, `prescale <= 0`, `tone_count <= 0`, state → PLAYING.
    - `sounder` keeps its current level; it is 0 when starting from IDLE.
    - Applies in either state; mid-tone it restarts the tone with the new duration.
  - `data_in[15:0]` = 0: state → IDLE, `sounder <= 0` (cancel).
- Status register: read-only. Writes to `tonegen_status_cs` are ignored.
- PLAYING, per clock:
  - Prescaler:
    - If `prescale == TICK_DIVIDE-1`: `prescale <= 0` and `duration_count` decrements.
    - If that decrement takes `duration_count` from 1 to 0: state → IDLE and `sounder <= 0` on the same edge.
    - Otherwise `prescale` increments.
  - Tone:
    - If `period == 0`: `sounder <= 0`, `tone_count <= 0`.
    - Else if `tone_count >= period-1`: `tone_count <= 0`, `sounder` toggles.
    - Else `tone_count` increments.
    - The `>=` compare guarantees no lock-up when period is reduced below the current count.
  - The end-of-duration action takes priority over the tone toggle on the same edge.
- IDLE: all counters hold, `sounder` = 0.
- Duration write in the same cycle as the final tick: the write wins (tone restarts).
- `tonegen_data_out` is driven every cycle regardless of valid. The mux uses valid only.

## Timing

- Reset (`reset`=0 on an edge):
  - `period`=0, `duration_count`=0, `prescale`=0, `tone_count`=0, `playing`=0, `sounder`=0.
  - Applies mid-tone: the output stops on that edge.
- Reads: zero-latency combinational. `tonegen_data_out_valid` and data are valid in the same cycle as `read & tonegen_status_cs`.
- Duration write on edge E: `playing`=1 is visible after E.
- With period P ≥ 1: the first `sounder` toggle occurs at edge E+P, then every P edges (full wave period 2P clocks).
- Duration N: `playing` falls (and `sounder` forced 0) at edge E + N·TICK_DIVIDE.
  - PLAYING therefore lasts exactly N·TICK_DIVIDE clocks.
- Period write mid-tone: the new value is used in the compare on the following edge.

## Test plan

- Reset/idle: hold `reset`=0 for 2 clocks, release, read status → `tonegen_data_out`=0x00000000 with valid=1, `sounder`=0. With `read`=0 or a different select, valid=0.
- Basic tone (TICK_DIVIDE=4): write period=3, then duration=2.
  - `sounder` rises at E+3, falls at E+6.
  - Status reads 1 through E+7; `playing`=0 and `sounder`=0 from E+8.
- Cancel: during a tone with period=5 and duration=100, write duration=0 → next cycle status=0 and `sounder`=0. No further toggles over 50 clocks.
- Period shrink: period=10, start tone. When `tone_count`=6, write period=2 → toggle on the next edge, then every 2 clocks.
- Restart and priority (TICK_DIVIDE=4, duration=1): write duration=3 on the edge where the final tick expires.
  - `playing` stays 1.
  - Tone ends 12 clocks after that write.
- Reset mid-tone: at `sounder`=1 assert `reset`=0 for 1 clock.
  - `sounder`=0 and status=0 after that edge.
  - `period` reads back as 0 in effect: a new duration write yields no toggles.

Source files
------------

// File: rtl/tonegen.sv
// ---------------------------------------------------------------------------
// tonegen: square-wave tone generator for the beeper/piezo output.
//
// A write to the duration register starts a 50% duty square wave whose
// half-period (in clocks) comes from the period register.  The tone lasts a
// programmed number of duration ticks, each tick being TICK_DIVIDE clocks.
// A zero duration write cancels a running tone.  The status register reports
// whether a tone is currently playing.
//
// Parameters:
//   TICK_DIVIDE            clocks per duration tick (>= 1)
//
// Ports:
//   clock                  system clock, rising edge
//   reset                  synchronous reset, active low
//   write                  CPU write strobe (qualified by a select)
//   read                   CPU read strobe (qualified by a select)
//   data_in[31:0]          CPU write data, only [15:0] used
//   tonegen_period_cs      period register select
//   tonegen_duration_cs    duration register select (write starts/cancels)
//   tonegen_status_cs      status register select (read only)
//   tonegen_data_out[31:0] read data {31'b0, playing}, driven every cycle
//   tonegen_data_out_valid read & tonegen_status_cs, combinational
//   sounder                square-wave output to the pin
// ---------------------------------------------------------------------------
module tonegen #(
  parameter int unsigned TICK_DIVIDE = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] data_in,
  input  logic        tonegen_period_cs,
  input  logic        tonegen_duration_cs,
  input  logic        tonegen_status_cs,
  output logic [31:0] tonegen_data_out,
  output logic        tonegen_data_out_valid,
  output logic        sounder
);

  // Keep the prescaler at least one bit wide when TICK_DIVIDE == 1.
  localparam int unsigned PrescaleW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
  localparam logic [PrescaleW-1:0] PrescaleMax = PrescaleW'(TICK_DIVIDE - 1);

  typedef enum logic {
    StIdle,
    StPlaying
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                r_state;
  state_e                w_state_next;
  logic [15:0]           r_period;
  logic [15:0]           w_period_next;
  logic [15:0]           r_duration_count;
  logic [15:0]           w_duration_count_next;
  logic [PrescaleW-1:0]  r_prescale;
  logic [PrescaleW-1:0]  w_prescale_next;
  logic [15:0]           r_tone_count;
  logic [15:0]           w_tone_count_next;
  logic                  r_sounder;
  logic                  w_sounder_next;

  // ---------------------------------------------------------------------------
  // Decoded strobes and compares
  // ---------------------------------------------------------------------------
  logic        w_playing;
  logic        w_period_wr;
  logic        w_dur_wr;
  logic [15:0] w_dur_val;
  logic        w_dur_start;
  logic        w_dur_cancel;
  logic        w_tick;
  logic        w_last_tick;
  logic        w_tone_wrap;
  logic        w_unused_data;

  assign w_period_wr  = write & tonegen_period_cs;
  assign w_dur_wr     = write & tonegen_duration_cs;
  assign w_dur_val    = data_in[15:0];
  assign w_dur_start  = w_dur_wr & (w_dur_val != 16'd0);
  assign w_dur_cancel = w_dur_wr & (w_dur_val == 16'd0);
  assign w_tick       = (r_prescale == PrescaleMax);
  // Tick that takes the remaining duration from 1 to 0 ends the tone.
  assign w_last_tick  = w_playing & w_tick & (r_duration_count == 16'd1);
  // >= rather than == so a period shrunk below the current count still wraps.
  // Only consulted when r_period != 0, so the subtraction cannot underflow.
  assign w_tone_wrap  = (r_tone_count >= (r_period - 16'd1));

  assign w_unused_data = ^data_in[31:16];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // A duration write wins over the end-of-tone tick on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_dur_start) begin
          w_state_next = StPlaying;
        end
      end
      StPlaying: begin
        if (w_dur_start) begin
          w_state_next = StPlaying;
        end else if (w_dur_cancel || w_last_tick) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_playing              = (r_state == StPlaying);
    tonegen_data_out       = {31'b0, w_playing};
    tonegen_data_out_valid = read & tonegen_status_cs;
  end

  assign sounder = r_sounder;

  // ---------------------------------------------------------------------------
  // Datapath next state: period, prescaler, duration, tone counter, sounder
  // ---------------------------------------------------------------------------
  always_comb begin
    w_period_next         = r_period;
    w_duration_count_next = r_duration_count;
    w_prescale_next       = r_prescale;
    w_tone_count_next     = r_tone_count;
    w_sounder_next        = r_sounder;

    if (w_period_wr) begin
      w_period_next = w_dur_val;
    end

    if (w_dur_start) begin
      // Restart: sounder keeps its level so a mid-tone restart is glitch free.
      w_duration_count_next = w_dur_val;
      w_prescale_next       = '0;
      w_tone_count_next     = 16'd0;
    end else if (w_dur_cancel) begin
      w_sounder_next = 1'b0;
    end else if (w_playing) begin
      // Duration prescaler.
      if (w_tick) begin
        w_prescale_next       = '0;
        w_duration_count_next = r_duration_count - 16'd1;
      end else begin
        w_prescale_next = r_prescale + PrescaleW'(1);
      end

      // Tone half-period counter.
      if (r_period == 16'd0) begin
        w_sounder_next    = 1'b0;
        w_tone_count_next = 16'd0;
      end else if (w_tone_wrap) begin
        w_tone_count_next = 16'd0;
        w_sounder_next    = ~r_sounder;
      end else begin
        w_tone_count_next = r_tone_count + 16'd1;
      end

      // End of duration overrides any toggle on the same edge.
      if (w_last_tick) begin
        w_sounder_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_period         <= 16'd0;
      r_duration_count <= 16'd0;
      r_prescale       <= '0;
      r_tone_count     <= 16'd0;
      r_sounder        <= 1'b0;
    end else begin
      r_period         <= w_period_next;
      r_duration_count <= w_duration_count_next;
      r_prescale       <= w_prescale_next;
      r_tone_count     <= w_tone_count_next;
      r_sounder        <= w_sounder_next;
    end
  end

endmodule

// File: tb/tb_tonegen.sv
// ---------------------------------------------------------------------------
// tb_tonegen: self-checking bench for tonegen with TICK_DIVIDE = 4.
// A time-based reference model tracks the tone end cycle and the cycle at
// which the half-period count last restarted; status reads push expected
// data into a queue that a separate monitor pops when valid appears.
// ---------------------------------------------------------------------------
module tb_tonegen;

  localparam int TD = 4;

  logic        clock;
  logic        reset;
  logic        write;
  logic        read;
  logic [31:0] data_in;
  logic        period_cs;
  logic        duration_cs;
  logic        status_cs;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        snd;

  tonegen #(
    .TICK_DIVIDE(TD)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .write                 (write),
    .read                  (read),
    .data_in               (data_in),
    .tonegen_period_cs     (period_cs),
    .tonegen_duration_cs   (duration_cs),
    .tonegen_status_cs     (status_cs),
    .tonegen_data_out      (data_out),
    .tonegen_data_out_valid(data_out_valid),
    .sounder               (snd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model, evaluated per rising edge number t.
  // Tone: count before edge t equals (t-1) - m_ref, so a toggle happens once
  // (t - m_ref) >= period. Duration: tone ends at absolute edge m_end.
  // ---------------------------------------------------------------------------
  int   t = 0;
  int   m_end = 0;
  int   m_ref = 0;
  int   m_period = 0;
  bit   m_play = 0;
  bit   m_snd = 0;
  bit   m_dw;
  int   toggles = 0;

  always @(posedge clock) begin
    t = t + 1;
    m_dw = write & duration_cs;
    if (!reset) begin
      m_period = 0;
      m_play   = 0;
      m_snd    = 0;
      m_ref    = t;
    end else begin
      if (m_dw && data_in[15:0] != 16'd0) begin
        m_play = 1;
        m_end  = t + int'(data_in[15:0]) * TD;
        m_ref  = t;
      end else if (m_dw) begin
        m_play = 0;
        m_snd  = 0;
      end else if (m_play) begin
        if (t == m_end) begin
          m_play = 0;
          m_snd  = 0;
        end else if (m_period == 0) begin
          m_snd = 0;
          m_ref = t;
        end else if ((t - m_ref) >= m_period) begin
          m_snd   = ~m_snd;
          m_ref   = t;
          toggles = toggles + 1;
        end
      end
      if (write & period_cs) m_period = int'(data_in[15:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  bit          exp_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s at t=%0d: got 0x%08h expected 0x%08h", name, t, act, req);
    end
  endtask

  always @(negedge clock) begin
    #2;
    chk("sounder", {31'b0, snd}, {31'b0, m_snd});
    chk("data_out", data_out, {31'b0, m_play});
    chk("valid", {31'b0, data_out_valid}, {31'b0, exp_valid});
    if (data_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        chk("status_read", data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: drive one cycle of inputs at the falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit rst_n, input bit w, input bit r, input bit pcs,
                     input bit dcs, input bit scs, input logic [15:0] d);
    reset       = rst_n;
    write       = w;
    read        = r;
    period_cs   = pcs;
    duration_cs = dcs;
    status_cs   = scs;
    data_in     = {$urandom_range(0, 65535), d};
    exp_valid   = r & scs;
    if (r && scs) exp_q.push_back({31'b0, m_play});
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 0, 1, 16'd0);
  endtask

  task automatic wr_period(input logic [15:0] p);
    cyc(1, 1, 0, 1, 0, 0, p);
  endtask

  task automatic wr_dur(input logic [15:0] n);
    cyc(1, 1, 0, 0, 1, 0, n);
  endtask

  int snap;
  int bound;

  initial begin
    reset = 0; write = 0; read = 0; data_in = 0;
    period_cs = 0; duration_cs = 0; status_cs = 0;
    @(negedge clock);
    // Reset held for two clocks, then status read and non-status reads.
    cyc(0, 0, 0, 0, 0, 0, 16'd0);
    cyc(1, 0, 1, 0, 0, 1, 16'd0);
    cyc(1, 0, 0, 0, 0, 1, 16'd0);
    cyc(1, 0, 1, 1, 0, 0, 16'd0);
    cyc(1, 1, 1, 0, 0, 1, 16'd5);  // status write ignored

    // Basic tone: period 3, duration 2.
    wr_period(16'd3);
    wr_dur(16'd2);
    idle(12);

    // Cancel mid-tone, then confirm no toggles over 50 clocks.
    wr_period(16'd5);
    wr_dur(16'd100);
    idle(20);
    wr_dur(16'd0);
    snap = toggles;
    idle(50);
    chk("no_toggle_after_cancel", toggles, snap);

    // Period shrink when the half-period count reaches 6.
    wr_period(16'd10);
    wr_dur(16'd20);
    idle(5);
    wr_period(16'd2);
    idle(10);
    wr_dur(16'd0);

    // Restart on the edge of the final tick.
    wr_period(16'd1);
    wr_dur(16'd1);
    bound = 0;
    while (t != m_end - 1 && bound < 20) begin
      idle(1);
      bound++;
    end
    chk("final_tick_reached", {31'b0, (t == m_end - 1)}, 32'd1);
    wr_dur(16'd3);
    chk("restart_end", m_end - t, 32'(3 * TD));
    idle(16);

    // Reset mid-tone while sounder is high.
    wr_period(16'd3);
    wr_dur(16'd5);
    bound = 0;
    while (!m_snd && bound < 20) begin
      idle(1);
      bound++;
    end
    chk("sounder_high_before_reset", {31'b0, m_snd}, 32'd1);
    cyc(0, 0, 1, 0, 0, 1, 16'd0);
    snap = toggles;
    wr_dur(16'd3);
    idle(14);
    chk("no_toggle_after_reset", toggles, snap);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      if (op < 2) cyc(0, 0, $urandom_range(0, 1), 0, 0, 1, 16'd0);
      else if (op < 10) wr_period(16'($urandom_range(0, 5)));
      else if (op < 14) wr_dur(16'($urandom_range(0, 4)));
      else if (op < 16)
        cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0,
            $urandom_range(0, 1), 16'($urandom_range(0, 7)));
      else cyc(1, 0, $urandom_range(0, 1), 0, 0, $urandom_range(0, 1), 16'd0);
    end

    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 16'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
